// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_ack;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wmask;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ack;
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wmask;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_ready;
    logic                  owner;
    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ready,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_wmask,
               owner, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_wmask,
               owner, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (I) and data (D) requesters
// Optional I starvation guard: define MEM_PORT_ARBITER_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t              state;
    logic                m_req_q;
    logic                m_we_q;
    logic                owner_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [MASK_W-1:0]   m_wmask_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic completing, arb_point, i_cand, d_cand, starve, grant_i, grant_d, i_ack_c, d_ack_c;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT)) && bus.i_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.i_req && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Strict D priority; the limit only matters when the guard is built in.
    assign starve = (STARVE_LIMIT < 0);
`endif

    // The finishing owner's request is masked so the other side gets the port with no bubble.
    always_comb begin
        completing = m_req_q && bus.m_ready && !reset;
        i_ack_c    = completing && (state == SERVE_I);
        d_ack_c    = completing && (state == SERVE_D);
        arb_point  = (state == IDLE) || completing;
        i_cand     = bus.i_req && (state != SERVE_I);
        d_cand     = bus.d_req && (state != SERVE_D);
        grant_i    = arb_point && i_cand && (!d_cand || starve);
        grant_d    = arb_point && d_cand && !grant_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant_d) begin
                state     <= SERVE_D;
                m_req_q   <= 1'b1;
                busy_q    <= 1'b1;
                owner_q   <= 1'b1;
                m_we_q    <= bus.d_we;
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_wdata;
                m_wmask_q <= bus.d_wmask;
            end else if (grant_i) begin
                state     <= SERVE_I;
                m_req_q   <= 1'b1;
                busy_q    <= 1'b1;
                owner_q   <= 1'b0;
                m_we_q    <= 1'b0;
                m_addr_q  <= bus.i_addr;
                m_wdata_q <= '0;
                m_wmask_q <= '0;
            end else if (completing) begin
                state     <= IDLE;
                m_req_q   <= 1'b0;
                busy_q    <= 1'b0;
            end
            if (i_ack_c) i_rdata_q <= bus.m_rdata;
            if (d_ack_c) d_rdata_q <= bus.m_rdata;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wmask = m_wmask_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.i_ack   = i_ack_c;
    assign bus.d_ack   = d_ack_c;
    assign bus.i_rdata = i_ack_c ? bus.m_rdata : i_rdata_q;
    assign bus.d_rdata = d_ack_c ? bus.m_rdata : d_rdata_q;
endmodule
